// File: rtl/alu_op_sequencer.sv
// Registered operand/result stage around a 4-bit combinational ALU.
// Requests come in on a valid/ready handshake; one cycle later the result goes out on another.
module alu_op_sequencer #(
    parameter logic [3:0] ACC_INIT = 4'b0000,
    parameter bit         CHAIN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [3:0] in_a_i,
    input  logic [3:0] in_b_i,
    input  logic [2:0] in_op_i,
    input  logic       in_chain_i,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [2:0] alu_c_o,
    input  logic [3:0] alu_f_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [3:0] out_f_o,
    output logic [2:0] out_op_o,
    output logic       out_zero_o,
    output logic [3:0] acc_o,
    output logic [7:0] op_count_o
);

    // state | meaning
    // IDLE  | no operation in flight, ready for a request
    // EXEC  | operands on the ALU, result captured at the next edge
    // HOLD  | result presented downstream, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_c_q, alu_c_d;
    logic [3:0] out_f_q, out_f_d;
    logic [2:0] out_op_q, out_op_d;
    logic       out_zero_q, out_zero_d;
    logic [3:0] acc_q, acc_d;
    logic [7:0] op_count_q, op_count_d;

    logic in_ready;
    logic accept;
    logic handoff;
    logic use_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_c_q    <= 3'd0;
            out_f_q    <= 4'd0;
            out_op_q   <= 3'd0;
            out_zero_q <= 1'b0;
            acc_q      <= ACC_INIT;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_c_q    <= alu_c_d;
            out_f_q    <= out_f_d;
            out_op_q   <= out_op_d;
            out_zero_q <= out_zero_d;
            acc_q      <= acc_d;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_c_d    = alu_c_q;
        out_f_d    = out_f_q;
        out_op_d   = out_op_q;
        out_zero_d = out_zero_q;
        acc_d      = acc_q;
        op_count_d = op_count_q;

        // in_ready must not depend on in_valid, so it is built from state and out_ready only.
        in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready_i);
        accept   = in_valid_i && in_ready;
        handoff  = (state_q == HOLD) && out_ready_i;
        use_acc  = CHAIN_EN && in_chain_i;

        if (accept) begin
            alu_a_d = use_acc ? acc_q : in_a_i;
            alu_b_d = in_b_i;
            alu_c_d = in_op_i;
        end

        if (handoff) begin
            op_count_d = op_count_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_f_d    = alu_f_i;
                out_op_d   = alu_c_q;
                out_zero_d = (alu_f_i == 4'd0);
                acc_d      = alu_f_i;
                state_d    = HOLD;
            end
            HOLD: begin
                if (handoff) begin
                    state_d = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready_o  = in_ready;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_c_o     = alu_c_q;
    assign out_valid_o = (state_q == HOLD);
    assign out_f_o     = out_f_q;
    assign out_op_o    = out_op_q;
    assign out_zero_o  = out_zero_q;
    assign acc_o       = acc_q;
    assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (chaining on/off) driven in lockstep,
// a transaction-level model checked every cycle, plus hand-computed directed expectations.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       in_chain;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;

    logic       in_ready  [2];
    logic [3:0] alu_a     [2];
    logic [3:0] alu_b     [2];
    logic [2:0] alu_c     [2];
    logic [3:0] alu_f     [2];
    logic       out_valid [2];
    logic [3:0] out_f     [2];
    logic [2:0] out_op    [2];
    logic       out_zero  [2];
    logic [3:0] acc       [2];
    logic [7:0] op_count  [2];

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    // Reference 4-bit ALU; also serves as the ALU the DUTs are wired to.
    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        logic [7:0] p;
        p = a * b;
        case (c)
            3'd0:    return 4'(5'd16 - {1'b0, a});
            3'd1:    return 4'(5'd16 - {1'b0, b});
            3'd2:    return 4'(a + b);
            3'd3:    return 4'(a - b);
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return p[3:0];
            default: return a ^ b;
        endcase
    endfunction

    assign alu_f[0] = alu_fn(alu_a[0], alu_b[0], alu_c[0]);
    assign alu_f[1] = alu_fn(alu_a[1], alu_b[1], alu_c[1]);

    alu_op_sequencer #(.ACC_INIT(4'b0000), .CHAIN_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .in_a_i(in_a), .in_b_i(in_b), .in_op_i(in_op), .in_chain_i(in_chain),
        .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_c_o(alu_c[0]), .alu_f_i(alu_f[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .out_f_o(out_f[0]), .out_op_o(out_op[0]), .out_zero_o(out_zero[0]),
        .acc_o(acc[0]), .op_count_o(op_count[0])
    );

    alu_op_sequencer #(.ACC_INIT(4'b0000), .CHAIN_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .in_a_i(in_a), .in_b_i(in_b), .in_op_i(in_op), .in_chain_i(in_chain),
        .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_c_o(alu_c[1]), .alu_f_i(alu_f[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .out_f_o(out_f[1]), .out_op_o(out_op[1]), .out_zero_o(out_zero[1]),
        .acc_o(acc[1]), .op_count_o(op_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: one request in flight (busy), one result on offer (valid).
    bit         m_busy  [2];
    bit         m_valid [2];
    logic [3:0] m_a     [2];
    logic [3:0] m_b     [2];
    logic [2:0] m_c     [2];
    logic [3:0] m_f     [2];
    logic [2:0] m_op    [2];
    bit         m_zero  [2];
    logic [3:0] m_acc   [2];
    logic [7:0] m_cnt   [2];

    function automatic bit m_ready(input int i);
        return !m_busy[i] && (!m_valid[i] || out_ready);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_busy[i] = 0; m_valid[i] = 0;
                    m_a[i] = 0; m_b[i] = 0; m_c[i] = 0;
                    m_f[i] = 0; m_op[i] = 0; m_zero[i] = 0;
                    m_acc[i] = 4'b0000; m_cnt[i] = 0;
                end else if (m_busy[i]) begin
                    m_f[i]     = alu_fn(m_a[i], m_b[i], m_c[i]);
                    m_op[i]    = m_c[i];
                    m_zero[i]  = (m_f[i] == 0);
                    m_acc[i]   = m_f[i];
                    m_valid[i] = 1;
                    m_busy[i]  = 0;
                end else begin
                    bit take;
                    take = in_valid && m_ready(i);
                    if (m_valid[i] && out_ready) begin
                        m_cnt[i]   = m_cnt[i] + 8'd1;
                        m_valid[i] = 0;
                    end
                    if (take) begin
                        m_a[i]    = (i == 0 && in_chain) ? m_acc[i] : in_a;
                        m_b[i]    = in_b;
                        m_c[i]    = in_op;
                        m_busy[i] = 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("d%0d_in_ready", i), in_ready[i], m_ready(i));
                    chk($sformatf("d%0d_out_valid", i), out_valid[i], m_valid[i]);
                    chk($sformatf("d%0d_out_f", i), out_f[i], m_f[i]);
                    chk($sformatf("d%0d_out_op", i), out_op[i], m_op[i]);
                    chk($sformatf("d%0d_out_zero", i), out_zero[i], m_zero[i]);
                    chk($sformatf("d%0d_acc", i), acc[i], m_acc[i]);
                    chk($sformatf("d%0d_op_count", i), op_count[i], m_cnt[i]);
                    chk($sformatf("d%0d_alu_a", i), alu_a[i], m_a[i]);
                    chk($sformatf("d%0d_alu_b", i), alu_b[i], m_b[i]);
                    chk($sformatf("d%0d_alu_c", i), alu_c[i], m_c[i]);
                end
            end
        end
    end

    // Present a request and return just after the edge that accepts it.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch);
        bit ok;
        @(posedge clk); #2;
        in_valid = 1; in_a = a; in_b = b; in_op = op; in_chain = ch;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready[0]) ok = 1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #2;
        in_valid = 0;
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch,
                          input int exp0, input int exp1, input int expz, input int expcnt);
        out_ready = 1;
        issue(a, b, op, ch);
        @(negedge clk);
        chk("lat_exec_no_valid", out_valid[0], 0);
        @(negedge clk);
        chk("lat_valid", out_valid[0], 1);
        chk("res_f_chain", out_f[0], exp0);
        chk("res_f_nochain", out_f[1], exp1);
        chk("res_zero", out_zero[0], expz);
        chk("res_op", out_op[0], op);
        chk("res_acc", acc[0], exp0);
        @(negedge clk);
        chk("handoff_count", op_count[0], expcnt);
    endtask

    initial begin
        rst_n = 1; in_valid = 0; out_ready = 0; in_chain = 0;
        in_a = 0; in_b = 0; in_op = 0;
        #1 rst_n = 0;
        #1 check_en = 1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_acc", acc[0], 0);
        chk("rst_op_count", op_count[0], 0);
        chk("rst_alu_a", alu_a[0], 0);
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready[0], 1);

        run_op(4'd6,  4'd2,  3'd2, 1'b0, 8,  8, 0, 1);
        run_op(4'd15, 4'd3,  3'd2, 1'b1, 11, 2, 0, 2);
        run_op(4'd8,  4'd8,  3'd2, 1'b0, 0,  0, 1, 3);
        run_op(4'd6,  4'd3,  3'd4, 1'b0, 2,  2, 0, 4);
        run_op(4'd3,  4'd0,  3'd0, 1'b0, 13, 13, 0, 5);
        run_op(4'd0,  4'd9,  3'd1, 1'b0, 7,  7, 0, 6);
        run_op(4'd7,  4'd3,  3'd6, 1'b0, 5,  5, 0, 7);
        run_op(4'd12, 4'd10, 3'd7, 1'b0, 6,  6, 0, 8);
        run_op(4'd9,  4'd4,  3'd3, 1'b1, 2,  5, 0, 9);

        // Backpressure with a follow-on request waiting the whole time.
        out_ready = 0;
        @(posedge clk); #2;
        in_valid = 1; in_a = 4'd1; in_b = 4'd2; in_op = 3'd5; in_chain = 0;
        @(posedge clk); #2;
        in_a = 4'd5; in_b = 4'd1; in_op = 3'd3;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_out_f", out_f[0], 3);
            chk("bp_alu_a", alu_a[0], 1);
        end
        @(posedge clk); #2 out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", in_ready[0], 1);
        @(posedge clk); #2 in_valid = 0;
        @(negedge clk);
        chk("bp_exec_valid", out_valid[0], 0);
        chk("bp_new_alu_a", alu_a[0], 5);
        chk("bp_count", op_count[0], 10);
        @(negedge clk);
        chk("bp_new_f", out_f[0], 4);
        @(negedge clk);
        chk("bp_count2", op_count[0], 11);

        // Reset during EXEC.
        issue(4'd5, 4'd5, 3'd2, 1'b0);
        rst_n = 0; #1;
        chk("rst_exec_valid", out_valid[0], 0);
        chk("rst_exec_acc", acc[0], 0);
        chk("rst_exec_count", op_count[0], 0);
        @(posedge clk); #2 rst_n = 1;

        // Reset during HOLD.
        out_ready = 0;
        issue(4'd5, 4'd5, 3'd2, 1'b0);
        @(posedge clk); #1;
        chk("hold_before_rst", out_valid[0], 1);
        chk("hold_acc", acc[0], 10);
        #1 rst_n = 0; #1;
        chk("rst_hold_valid", out_valid[0], 0);
        chk("rst_hold_acc", acc[0], 0);
        chk("rst_hold_count", op_count[0], 0);
        @(posedge clk); #2 rst_n = 1; out_ready = 1;

        // 256 back-to-back operations: handoffs on edges 3,5,...,513.
        @(posedge clk); #2;
        in_valid = 1; in_a = 4'd1; in_b = 4'd1; in_op = 3'd2; in_chain = 1;
        repeat (511) @(posedge clk);
        @(negedge clk);
        chk("wrap_255", op_count[0], 255);
        repeat (2) @(posedge clk);
        #2 in_valid = 0;
        @(negedge clk);
        chk("wrap_0", op_count[0], 0);
        chk("wrap_0_nochain", op_count[1], 0);
        chk("wrap_acc", acc[0], 0);
        repeat (2) @(negedge clk);
        chk("wrap_drain", op_count[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1);
    end

endmodule
